truth_table_sweeper: RTL and testbench

- Self-contained stimulus/capture stage wrapped around a 4-input combinational function under test (the exercise circuits' a,b,c,d -> x blocks).
- Drives a,b,c,d through all 16 combinations, waits a settle interval per vector, samples x, and assembles a 16-bit truth-table word.
- Used on-board with switches/LEDs and in benches: result is compared against an expected table, with a pass flag and ones count.

---
 rtl/truth_table_sweeper.sv | 165 ++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// ----------------------------------------------------------------------------
// truth_table_sweeper
//
// Stimulus/capture stage for a 4-input combinational function under test.
// Walks {a,b,c,d} through all 16 input combinations. Each vector is held for
// SETTLE_CYCLES cycles so the function can settle. One further cycle then
// samples x_in. The 16 samples form a truth-table word that is published with
// a one-cycle done pulse, together with its ones count and a compare result
// against an expected table.
//
// Parameters:
//   SETTLE_CYCLES  cycles each vector is held before x_in is sampled (1..255)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous, active-high reset
//   start       in   level; sampled only in IDLE, starts a sweep
//   x_in        in   output of the function under test
//   exp_table   in   expected truth table, sampled on the edge entering DONE
//   a,b,c,d     out  stimulus vector, a = MSB, d = LSB
//   busy        out  high while a sweep is in progress (SETTLE/SAMPLE)
//   done        out  one-cycle pulse when table_out/ones_count/pass are new
//   table_out   out  captured table; bit k = x for {a,b,c,d} == k
//   ones_count  out  number of ones in table_out (0..16)
//   pass        out  table_out == exp_table
// ----------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        x_in,
    input  logic [15:0] exp_table,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic [4:0]  ones_count,
    output logic        pass
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Terminal value of the 8-bit settle counter.
    localparam logic [7:0] LP_CNT_LAST = 8'(SETTLE_CYCLES - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_idx;
    logic [7:0]  r_cnt;
    logic [15:0] r_shadow;
    logic [3:0]  r_abcd;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_table;
    logic [4:0]  r_ones;
    logic        r_pass;

    // Shadow as it will look after the current SAMPLE cycle. Used on the
    // final SAMPLE so the published table includes the last bit.
    logic [15:0] w_shadow_next;
    logic [4:0]  w_ones_next;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    //       path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_shadow_next        = r_shadow;
        w_shadow_next[r_idx] = x_in;
        w_ones_next          = '0;
        for (int k = 0; k < 16; k++) begin
            w_ones_next = w_ones_next + {4'b0000, w_shadow_next[k]};
        end
    end

    // NOTE: all state is updated with non-blocking assignments, so every
    //       register in this block sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_abcd   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_table  <= '0;
            r_ones   <= '0;
            r_pass   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_abcd <= '0;
                    r_done <= 1'b0;
                    if (start) begin
                        r_idx    <= '0;
                        r_cnt    <= '0;
                        r_shadow <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_SETTLE;
                    end
                end

                // x_in is deliberately ignored here; glitches while the
                // function settles never reach the shadow register.
                S_SETTLE: begin
                    if (r_cnt == LP_CNT_LAST) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                S_SAMPLE: begin
                    r_shadow <= w_shadow_next;
                    if (r_idx == 4'd15) begin
                        // Publish the finished sweep on the edge entering DONE.
                        r_table <= w_shadow_next;
                        r_ones  <= w_ones_next;
                        r_pass  <= (w_shadow_next == exp_table);
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_abcd  <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + 4'd1;
                        r_abcd  <= r_idx + 4'd1;
                        r_cnt   <= '0;
                        r_state <= S_SETTLE;
                    end
                end

                // Single-cycle state; start is not looked at, so a request
                // arriving now is dropped rather than queued.
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_abcd  <= '0;
                end
            endcase
        end
    end

    assign a          = r_abcd[3];
    assign b          = r_abcd[2];
    assign c          = r_abcd[1];
    assign d          = r_abcd[0];
    assign busy       = r_busy;
    assign done       = r_done;
    assign table_out  = r_table;
    assign ones_count = r_ones;
    assign pass       = r_pass;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// ----------------------------------------------------------------------------
// tb_truth_table_sweeper
//
// Bench for truth_table_sweeper with SETTLE_CYCLES = 2. A behavioural model of
// the function under test drives x_in from the stimulus outputs. Expected
// results are pushed to a scoreboard queue when a sweep is started and are
// popped when the done pulse appears.
// ----------------------------------------------------------------------------
module tb_truth_table_sweeper;

    localparam int SETTLE = 2;
    localparam int HOLD   = SETTLE + 1;
    localparam int DONE_CYCLE = 16 * HOLD + 1;

    // Function selectors for the model of the circuit under test.
    localparam int F_AND  = 0;
    localparam int F_XOR  = 1;
    localparam int F_ONE  = 2;
    localparam int F_ZERO = 3;
    localparam int F_NOTD = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        x_in;
    logic [15:0] exp_table;
    logic        a, b, c, d;
    logic        busy;
    logic        done;
    logic [15:0] table_out;
    logic [4:0]  ones_count;
    logic        pass;

    int mode;
    int checks;
    int errors;

    typedef struct packed {
        logic [15:0] tbl;
        logic [4:0]  ones;
        logic        pass;
    } exp_t;

    exp_t sb_q[$];

    truth_table_sweeper #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .x_in       (x_in),
        .exp_table  (exp_table),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .busy       (busy),
        .done       (done),
        .table_out  (table_out),
        .ones_count (ones_count),
        .pass       (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_f(input int m, input logic [3:0] v);
        case (m)
            F_AND:   return v[3] & v[2];
            F_XOR:   return v[3] ^ v[2] ^ v[1] ^ v[0];
            F_ONE:   return 1'b1;
            F_ZERO:  return 1'b0;
            F_NOTD:  return ~v[0];
            default: return 1'b0;
        endcase
    endfunction

    always_comb x_in = model_f(mode, {a, b, c, d});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input int m, input logic [15:0] et);
        exp_t e;
        logic [3:0] v;
        e.tbl  = '0;
        e.ones = '0;
        for (int k = 0; k < 16; k++) begin
            v = 4'(k);
            e.tbl[k] = model_f(m, v);
            if (e.tbl[k]) e.ones = e.ones + 5'd1;
        end
        e.pass = (e.tbl == et);
        sb_q.push_back(e);
    endtask

    // Compare the DUT result against the oldest scoreboard entry.
    task automatic pop_and_compare(output exp_t e);
        e = '0;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: done seen with no expected entry");
        end else begin
            e = sb_q.pop_front();
            checks += 2;
            if (table_out !== e.tbl) begin
                errors++;
                $display("FAIL table_out: got %h expected %h", table_out, e.tbl);
            end
            if (ones_count !== e.ones) begin
                errors++;
                $display("FAIL ones_count: got %0d expected %0d", ones_count, e.ones);
            end
            if (pass !== e.pass) begin
                errors++;
                $display("FAIL pass: got %b expected %b", pass, e.pass);
            end
        end
    endtask

    // One complete sweep from a start pulse. Checks the stimulus sequence,
    // busy duration, done timing, result, one-cycle done and result hold.
    // With poke_start set, start is re-pulsed at cycle 10 mid-sweep.
    task automatic run_sweep(input int m, input logic [15:0] et, input bit poke_start);
        int   cyc;
        int   busy_cnt;
        int   seq_err;
        exp_t e;
        mode      = m;
        exp_table = et;
        push_expect(m, et);
        start = 1'b1;
        tick();
        start    = 1'b0;
        cyc      = 1;
        busy_cnt = 0;
        seq_err  = 0;
        while (!done && cyc < 200) begin
            if (busy) busy_cnt++;
            if (cyc < DONE_CYCLE && {a, b, c, d} !== 4'((cyc - 1) / HOLD)) begin
                seq_err++;
                if (seq_err <= 4)
                    $display("FAIL stimulus cycle %0d: got %0d expected %0d",
                             cyc, {a, b, c, d}, (cyc - 1) / HOLD);
            end
            if (poke_start && cyc == 10) start = 1'b1;
            if (poke_start && cyc == 11) start = 1'b0;
            tick();
            cyc++;
        end
        checks++;
        if (seq_err != 0) errors++;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", cyc);
            return;
        end
        checks += 4;
        if (cyc !== DONE_CYCLE) begin
            errors++;
            $display("FAIL done_cycle: got %0d expected %0d", cyc, DONE_CYCLE);
        end
        if (busy_cnt !== 16 * HOLD) begin
            errors++;
            $display("FAIL busy_cycles: got %0d expected %0d", busy_cnt, 16 * HOLD);
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_done: got %b expected 0", busy);
        end
        if ({a, b, c, d} !== 4'd0) begin
            errors++;
            $display("FAIL abcd_in_done: got %0d expected 0", {a, b, c, d});
        end
        pop_and_compare(e);
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_width: got %b expected 0 one cycle after done", done);
        end
        tick();
        tick();
        checks += 2;
        if (table_out !== e.tbl) begin
            errors++;
            $display("FAIL table_hold: got %h expected %h", table_out, e.tbl);
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks += 3;
        if ({a, b, c, d, busy, done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000", {a, b, c, d, busy, done});
        end
        if (table_out !== 16'h0000 || ones_count !== 5'd0) begin
            errors++;
            $display("FAIL reset_result: got %h/%0d expected 0000/0", table_out, ones_count);
        end
        if (pass !== 1'b0) begin
            errors++;
            $display("FAIL reset_pass: got %b expected 0", pass);
        end
    endtask

    task automatic test_and();
        run_sweep(F_AND, 16'hF000, 1'b0);
    endtask

    task automatic test_xor_mismatch();
        run_sweep(F_XOR, 16'h6997, 1'b0);
    endtask

    task automatic test_constants();
        run_sweep(F_ONE, 16'hFFFF, 1'b0);
        run_sweep(F_ZERO, 16'h0000, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_sweep(F_AND, 16'hF000, 1'b1);
    endtask

    task automatic test_back_to_back();
        int   cyc;
        int   n_done;
        int   last_done;
        exp_t e;
        mode      = F_NOTD;
        exp_table = 16'h5555;
        for (int i = 0; i < 3; i++) push_expect(F_NOTD, 16'h5555);
        start = 1'b1;
        tick();
        cyc       = 1;
        n_done    = 0;
        last_done = 0;
        while (n_done < 3 && cyc < 300) begin
            if (done) begin
                n_done++;
                checks++;
                if (cyc - last_done !== ((n_done == 1) ? DONE_CYCLE : DONE_CYCLE + 1)) begin
                    errors++;
                    $display("FAIL b2b_period %0d: got %0d expected %0d", n_done,
                             cyc - last_done, (n_done == 1) ? DONE_CYCLE : DONE_CYCLE + 1);
                end
                last_done = cyc;
                pop_and_compare(e);
                if (n_done == 3) start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (n_done !== 3) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d done pulses expected 3", n_done);
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: got busy %b expected 0 after start dropped", busy);
        end
    endtask

    task automatic test_mid_reset();
        int cyc;
        int seen_done;
        mode      = F_XOR;
        exp_table = 16'h6996;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        while ({a, b, c, d} !== 4'd7 && cyc < 100) begin
            tick();
            cyc++;
        end
        checks++;
        if ({a, b, c, d} !== 4'd7) begin
            errors++;
            $display("FAIL midrst_reach: got %0d expected 7", {a, b, c, d});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks += 2;
        if ({a, b, c, d, busy, done} !== 6'b0) begin
            errors++;
            $display("FAIL midrst_ctrl: got %b expected 000000", {a, b, c, d, busy, done});
        end
        if (table_out !== 16'h0000 || ones_count !== 5'd0 || pass !== 1'b0) begin
            errors++;
            $display("FAIL midrst_result: got %h/%0d/%b expected 0000/0/0",
                     table_out, ones_count, pass);
        end
        seen_done = 0;
        for (int i = 0; i < 60; i++) begin
            if (done || busy) seen_done++;
            tick();
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL midrst_quiet: got %0d active cycles expected 0", seen_done);
        end
        run_sweep(F_XOR, 16'h6996, 1'b0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        mode      = F_AND;
        rst       = 1'b1;
        start     = 1'b0;
        exp_table = 16'h0000;
        test_reset();
        test_and();
        test_xor_mismatch();
        test_constants();
        test_start_ignored();
        test_back_to_back();
        test_mid_reset();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
